alu_cmd_driver: RTL and testbench
=================================

// Module: alu_cmd_driver
// PURPOSE
//  Initiator side of the 5-bit ALU datapath: accepts operand/op commands over a valid/ready port,
//  drives the ALU A/B/OP inputs from registers, captures result + CF/SF/ZF one cycle later and
//  queues them in a response FIFO drained over a second valid/ready port. Sits between the
//  sequencer/test harness and the combinational ALU instance.
// PARAMETERS
//  W      5  operand/result width; must match the attached ALU
//  DEPTH  4  response FIFO entries; power of two, >=2
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  cmd_valid    in   1      command offered
//  cmd_ready    out  1      command accepted when cmd_valid&cmd_ready at rising edge
//  cmd_a        in   W      operand A
//  cmd_b        in   W      operand B
//  cmd_op       in   1      0 = OR/XOR/AND unit, 1 = ADD
//  alu_a        out  W      registered to ALU A
//  alu_b        out  W      registered to ALU B
//  alu_op       out  1      registered to ALU OP
//  alu_result   in   W      from ALU result
//  alu_cf       in   1      from ALU CF
//  alu_sf       in   1      from ALU SF
//  alu_zf       in   1      from ALU ZF
//  rsp_valid    out  1      FIFO head valid (= FIFO not empty)
//  rsp_ready    in   1      consumer pops head when rsp_valid&rsp_ready
//  rsp_result   out  W      head result
//  rsp_flags    out  3      head {cf,sf,zf}
//  rsp_op       out  1      head echoed op
// BEHAVIOUR
//  - Reset: FSM=IDLE, alu_a/alu_b/alu_op=0, FIFO empty (rd/wr ptr, count=0), rsp_valid=0,
//    rsp_result/rsp_flags/rsp_op=0, cmd_ready=0 while rst_n low. In-flight command is dropped.
//  - FSM: IDLE -> EXEC on accepted command; EXEC -> IDLE unconditionally after one cycle.
//  - cmd_ready = (state==IDLE) && (count < DEPTH); combinational, independent of cmd_valid.
//  - Accept (edge N): alu_a/alu_b/alu_op <= cmd_a/cmd_b/cmd_op; state <= EXEC.
//  - EXEC (cycle N+1): ALU outputs settle; at edge N+1 push {alu_op,alu_cf,alu_sf,alu_zf,alu_result}.
//  - rsp_valid rises at N+2 when FIFO was empty. Latency accept->response = 2 cycles.
//  - Throughput: one command per 2 cycles max; cmd_ready low during EXEC.
//  - alu_* hold last command after EXEC (no return to 0) until next accept.
//  - Flags captured verbatim; driver never recomputes CF/SF/ZF. Push never overflows: space is
//    guaranteed by the accept condition and pops only free entries.
//  - Full: count==DEPTH -> cmd_ready=0; pop at full frees space, cmd_ready high next cycle.
//  - Empty: rsp_ready ignored when rsp_valid=0; FIFO outputs show last-popped entry (don't-care).
//  - Simultaneous push+pop: count unchanged, both pointers advance; with count==0 push first,
//    no pop (no bypass; head visible next cycle).
//  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  - rst_n asserted mid-EXEC or mid-drain: everything clears immediately, no push occurs.
// CONFIGURATION
//  ALU_DRV_STICKY_EN defined: adds ports sticky_clr (in,1) and sticky_cf (out,1, reset 0).
//   sticky_cf <= 1 on any push with alu_cf=1; sticky_clr=1 clears it; clear+push same edge
//   -> set wins (result 1). Undefined: ports absent, no sticky logic.
// TESTING
//  1) Reset, cmd {a=3,b=4,op=1} -> cmd_ready 0 next cycle, rsp_valid at +2: result=7, flags=000.
//  2) {a=20,b=15,op=1} -> result=3, flags=100; {a=31,b=1,op=1} -> result=0, flags=101;
//     {a=16,b=0,op=1} -> result=16, flags=010.
//  3) op=0 cmd -> alu_op=0, CF flag=0, rsp_result equals ALU output unchanged, rsp_op=0.
//  4) rsp_ready=0, 4 back-to-back cmds -> 4 responses queued in order, cmd_ready=0;
//     one pop -> cmd_ready=1 next cycle; 5th response appended after wrap.
//  5) Assert rst_n low during EXEC -> no push, rsp_valid=0, all outputs 0 async.
//  6) ALU_DRV_STICKY_EN: 31+1 sets sticky_cf=1; 1+1 keeps 1; sticky_clr -> 0; clr+CF push -> 1.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------------------------
// alu_cmd_driver
//
// Initiator side of the small ALU datapath. A command (A, B, OP) is accepted over a valid/ready
// port and registered onto the ALU inputs. One cycle later the ALU result and CF/SF/ZF flags are
// captured verbatim into a response FIFO. The FIFO is drained over a second valid/ready port.
//
// Parameters
//   W       operand/result width, must match the attached ALU
//   DEPTH   response FIFO entries, power of two, >= 2
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (cmd_ready low while busy or FIFO full)
//   cmd_a, cmd_b, cmd_op        command payload (op: 0 = logic unit, 1 = ADD)
//   alu_a, alu_b, alu_op        registered ALU inputs; hold the last accepted command
//   alu_result, alu_cf/sf/zf    ALU outputs, sampled at the end of the EXEC cycle
//   rsp_valid/rsp_ready         response handshake (rsp_valid = FIFO not empty)
//   rsp_result, rsp_flags, rsp_op  FIFO head: result, {cf,sf,zf}, echoed op
//
// Optional feature (macro ALU_DRV_STICKY_EN)
//   sticky_clr (in)  clears the sticky carry flag
//   sticky_cf  (out) set by any push carrying CF=1; set wins over a same-edge clear
// ---------------------------------------------------------------------------------------------
module alu_cmd_driver #(
    parameter int unsigned W     = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_op,
    input  logic [W-1:0] alu_result,
    input  logic         alu_cf,
    input  logic         alu_sf,
    input  logic         alu_zf,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic [2:0]   rsp_flags,
`ifdef ALU_DRV_STICKY_EN
    output logic         rsp_op,
    input  logic         sticky_clr,
    output logic         sticky_cf
`else
    output logic         rsp_op
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    // Entry layout: {op, cf, sf, zf, result}
    localparam int unsigned EntW = W + 4;

    localparam logic StIdle = 1'b0;
    localparam logic StExec = 1'b1;

    logic            state_q, state_d;
    logic [W-1:0]    alu_a_q, alu_b_q;
    logic            alu_op_q;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic [EntW-1:0] mem_q [DEPTH];
    logic [EntW-1:0] head;
    logic            accept;
    logic            push;
    logic            pop;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // rst_n gates ready so nothing is offered as accepted while reset is held.
    assign cmd_ready = rst_n && (state_q == StIdle) && (count_q < CntW'(DEPTH));
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = (count_q != '0);
    // No bypass: an entry pushed while empty becomes visible only next cycle.
    assign pop       = rsp_valid && rsp_ready;
    // EXEC always pushes; space was reserved when the command was accepted.
    assign push      = (state_q == StExec);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // ALU input registers: hold the last command until the next accept
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= 1'b0;
        end else if (accept) begin
            alu_a_q  <= cmd_a;
            alu_b_q  <= cmd_b;
            alu_op_q <= cmd_op;
        end
    end

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {alu_op_q, alu_cf, alu_sf, alu_zf, alu_result};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign rsp_op     = head[EntW-1];
    assign rsp_flags  = head[W+2:W];
    assign rsp_result = head[W-1:0];

    // ------------------------------------------------------------------
    // Optional sticky carry
    // ------------------------------------------------------------------
`ifdef ALU_DRV_STICKY_EN
    logic sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (push && alu_cf) begin
            sticky_q <= 1'b1;
        end else if (sticky_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign sticky_cf = sticky_q;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// ---------------------------------------------------------------------------------------------
// tb_alu_cmd_driver
//
// Self-checking bench for alu_cmd_driver. Contains a behavioural ALU attached to the driver and
// a reference model (queue of expected responses plus a pending-execution flag) that predicts
// handshakes, ALU input registers and FIFO head contents every cycle. Build with
// +define+ALU_DRV_STICKY_EN to also exercise the sticky carry.
// ---------------------------------------------------------------------------------------------
module tb_alu_cmd_driver;

    localparam int W     = 5;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_op;
    logic [W-1:0] alu_result;
    logic         alu_cf;
    logic         alu_sf;
    logic         alu_zf;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic [2:0]   rsp_flags;
    logic         rsp_op;
    logic         sticky_clr;
    logic         sticky_cf;

    int vectors;
    int miscompares;

    alu_cmd_driver #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_cf     (alu_cf),
        .alu_sf     (alu_sf),
        .alu_zf     (alu_zf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
`ifdef ALU_DRV_STICKY_EN
        .rsp_op     (rsp_op),
        .sticky_clr (sticky_clr),
        .sticky_cf  (sticky_cf)
`else
        .rsp_op     (rsp_op)
`endif
    );

`ifndef ALU_DRV_STICKY_EN
    assign sticky_cf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: ADD with carry when op=1, XOR with CF=0 when op=0.
    // Returns {op, cf, sf, zf, result}.
    function automatic logic [8:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic op);
        int          sum;
        logic [4:0]  res;
        logic        cf;
        if (op) begin
            sum = int'(a) + int'(b);
            res = 5'(sum % 32);
            cf  = (sum >= 32);
        end else begin
            res = a ^ b;
            cf  = 1'b0;
        end
        return {op, cf, res[4], (res == 5'd0), res};
    endfunction

    always_comb begin
        {alu_cf, alu_sf, alu_zf, alu_result} = ref_alu(alu_a, alu_b, alu_op);
    end

    // Reference model state
    logic [8:0]   q [$];
    logic         pend;
    logic [8:0]   pend_ent;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic         eo;
    logic         est;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend = 1'b0;
        pend_ent = '0;
        ea = '0;
        eb = '0;
        eo = 1'b0;
        est = 1'b0;
    endtask

    // One clock: drive inputs, check all outputs at the falling edge, advance the model at the
    // rising edge, and return 1 time unit after it.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic op, input logic rr, input logic clr);
        logic acc;
        logic pp;
        logic exp_ready;
        cmd_valid  = v;
        cmd_a      = a;
        cmd_b      = b;
        cmd_op     = op;
        rsp_ready  = rr;
        sticky_clr = clr;
        @(negedge clk);
        exp_ready = !pend && (q.size() < DEPTH);
        chk("cmd_ready", 9'(cmd_ready), 9'(exp_ready));
        chk("rsp_valid", 9'(rsp_valid), 9'(q.size() > 0));
        chk("alu_in", {alu_op, alu_b, alu_a}[8:0], {eo, eb, ea}[8:0]);
        if (q.size() > 0) chk("rsp_head", {rsp_op, rsp_flags, rsp_result}, q[0]);
`ifdef ALU_DRV_STICKY_EN
        chk("sticky_cf", 9'(sticky_cf), 9'(est));
`endif
        acc = v && exp_ready;
        pp  = rr && (q.size() > 0);
        @(posedge clk);
        if (pp) void'(q.pop_front());
        if (pend) q.push_back(pend_ent);
        if (pend && pend_ent[7]) est = 1'b1;
        else if (clr) est = 1'b0;
        pend = acc;
        if (acc) begin
            pend_ent = ref_alu(a, b, op);
            ea = a;
            eb = b;
            eo = op;
        end
        #1;
    endtask

    task automatic idle(input logic rr);
        step(1'b0, '0, '0, 1'b0, rr, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_op      = 1'b0;
        rsp_ready   = 1'b0;
        sticky_clr  = 1'b0;
        model_reset();

        // Reset held: everything low
        rst_n = 1'b0;
        #12;
        chk("rst_cmd_ready", 9'(cmd_ready), 9'd0);
        chk("rst_rsp_valid", 9'(rsp_valid), 9'd0);
        chk("rst_head", {rsp_op, rsp_flags, rsp_result}, 9'd0);
        chk("rst_alu", {alu_op, alu_b, alu_a}[8:0], 9'd0);
        chk("rst_sticky", 9'(sticky_cf), 9'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 3 + 4 ADD: busy next cycle, response two cycles after accept
        step(1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
        chk("t1_busy", 9'(cmd_ready), 9'd0);
        chk("t1_novalid", 9'(rsp_valid), 9'd0);
        idle(1'b0);
        chk("t1_valid", 9'(rsp_valid), 9'd1);
        chk("t1_head", {rsp_op, rsp_flags, rsp_result}, {1'b1, 3'b000, 5'd7});
        idle(1'b1);

        // Flag corner cases, drained one at a time
        step(1'b1, 5'd20, 5'd15, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("t2_carry", {rsp_op, rsp_flags, rsp_result}, {1'b1, 3'b100, 5'd3});
        idle(1'b1);
        step(1'b1, 5'd31, 5'd1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("t2_zero", {rsp_op, rsp_flags, rsp_result}, {1'b1, 3'b101, 5'd0});
        idle(1'b1);
        step(1'b1, 5'd16, 5'd0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("t2_sign", {rsp_op, rsp_flags, rsp_result}, {1'b1, 3'b010, 5'd16});
        idle(1'b1);

        // Logic-unit command
        step(1'b1, 5'd12, 5'd10, 1'b0, 1'b0, 1'b0);
        chk("t3_alu_op", 9'(alu_op), 9'd0);
        idle(1'b0);
        chk("t3_head", {rsp_op, rsp_flags, rsp_result}, {1'b0, 3'b000, 5'd6});
        idle(1'b1);
        idle(1'b0);

        // Fill the FIFO with consumer stalled, free one slot, append across the wrap
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 5'($urandom), 5'($urandom), 1'b1, 1'b0, 1'b0);
        end
        chk("t4_full_ready", 9'(cmd_ready), 9'd0);
        chk("t4_depth", 9'(q.size()), 9'(DEPTH));
        idle(1'b1);
        chk("t4_freed_ready", 9'(cmd_ready), 9'd1);
        step(1'b1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 6; i++) idle(1'b1);
        chk("t4_drained", 9'(rsp_valid), 9'd0);

        // Reset during EXEC with entries queued: nothing pushed, outputs clear immediately
        step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        step(1'b1, 5'd30, 5'd3, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_cmd_ready", 9'(cmd_ready), 9'd0);
        chk("t5_rsp_valid", 9'(rsp_valid), 9'd0);
        chk("t5_head", {rsp_op, rsp_flags, rsp_result}, 9'd0);
        chk("t5_alu", {alu_op, alu_b, alu_a}[8:0], 9'd0);
        @(posedge clk);
        #1;
        chk("t5_no_push", 9'(rsp_valid), 9'd0);
        rst_n = 1'b1;
        model_reset();
        idle(1'b0);

`ifdef ALU_DRV_STICKY_EN
        // Sticky carry: set, hold, clear, and set-wins on a same-edge clear
        step(1'b1, 5'd31, 5'd1, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        chk("t6_set", 9'(sticky_cf), 9'd1);
        step(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        chk("t6_hold", 9'(sticky_cf), 9'd1);
        idle(1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("t6_clear", 9'(sticky_cf), 9'd0);
        step(1'b1, 5'd31, 5'd2, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("t6_set_wins", 9'(sticky_cf), 9'd1);
        idle(1'b1);
        idle(1'b1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0));
        end
        for (int i = 0; i < 8; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
